// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 OAM DMA engine and its bus arbiter.
package sm83_pkg;

  typedef logic [7:0]  word_t;
  typedef logic [15:0] adr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } dma_state_t;

  // DMA start/source register and the OAM window the copy lands in.
  localparam adr_t REG_ADR  = 16'hFF46;
  localparam adr_t OAM_BASE = 16'hFE00;

  // Source pages E0-FF are echo RAM; fold them back onto C000-DFFF.
  function automatic word_t map_src(input word_t v);
    return (v[7:5] == 3'b111) ? (v & 8'hDF) : v;
  endfunction

endpackage

// File: rtl/sm83_bus_arb.sv
// External-bus ownership mux between the sm83 core and the OAM DMA engine.
// While the DMA runs it owns the bus; the core may only touch the FF page,
// which lives inside the SoC and is therefore never forwarded to the bus.
module sm83_bus_arb
  import sm83_pkg::*;
#(
  parameter int                   ADR_WIDTH = 16,
  parameter int                   WORD_SIZE = 8,
  parameter logic [ADR_WIDTH-1:0] REG_ADR   = sm83_pkg::REG_ADR
) (
  input  logic                 i_run,
  input  logic [ADR_WIDTH-1:0] i_dma_adr,
  input  logic [ADR_WIDTH-1:0] i_cpu_adr,
  input  logic [WORD_SIZE-1:0] i_cpu_dout,
  input  logic                 i_cpu_rd,
  input  logic                 i_cpu_wr,
  input  logic [WORD_SIZE-1:0] i_reg_val,
  input  logic [WORD_SIZE-1:0] i_mem_din,
  output logic [ADR_WIDTH-1:0] o_mem_adr,
  output logic [WORD_SIZE-1:0] o_mem_dout,
  output logic                 o_mem_rd,
  output logic                 o_mem_wr,
  output logic [WORD_SIZE-1:0] o_cpu_din
);

  logic w_ff_page;
  logic w_reg_hit;

  assign w_ff_page = (i_cpu_adr[ADR_WIDTH-1 -: 8] == 8'hFF);
  assign w_reg_hit = (i_cpu_adr == REG_ADR);

  // Pass the core through when idle; hand the bus to the DMA while it runs.
  always_comb begin
    o_mem_adr  = i_cpu_adr;
    o_mem_dout = i_cpu_dout;
    o_mem_rd   = i_cpu_rd;
    o_mem_wr   = i_cpu_wr;
    o_cpu_din  = i_mem_din;
    if (i_run) begin
      o_mem_adr  = i_dma_adr;
      o_mem_dout = '0;
      o_mem_rd   = 1'b1;
      o_mem_wr   = 1'b0;
      // FF-page reads are served by SoC-internal registers layered over
      // cpu_din outside this block; everything else reads back as FF.
      o_cpu_din  = w_ff_page ? i_mem_din : '1;
    end
    if (i_cpu_rd && w_reg_hit) begin
      o_cpu_din = i_reg_val;
    end
  end

endmodule

// File: rtl/sm83_oam_dma.sv
// OAM DMA engine: a write to the DMA register copies OAM_LEN bytes from
// {src,00} into OAM, one byte per M-cycle, using a read stage that fetches
// from the external bus and a write stage one M-cycle behind it.
module sm83_oam_dma
  import sm83_pkg::*;
#(
  parameter int                   ADR_WIDTH = 16,
  parameter int                   WORD_SIZE = 8,
  parameter int                   OAM_LEN   = 160,
  parameter logic [ADR_WIDTH-1:0] REG_ADR   = sm83_pkg::REG_ADR
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 mcyc,
  input  logic [ADR_WIDTH-1:0] cpu_adr,
  input  logic [WORD_SIZE-1:0] cpu_dout,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  output logic [WORD_SIZE-1:0] cpu_din,
  output logic [ADR_WIDTH-1:0] mem_adr,
  output logic [WORD_SIZE-1:0] mem_dout,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic [WORD_SIZE-1:0] mem_din,
  output logic [7:0]           oam_adr,
  output logic [WORD_SIZE-1:0] oam_dout,
  output logic                 oam_we,
  output logic                 busy
);

  // OAM_LEN must lie in 1..256 so the byte index fits in eight bits.
  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_t           r_state;
  dma_state_t           w_state_nxt;
  logic [7:0]           r_idx;
  logic [7:0]           w_idx_nxt;
  logic [7:0]           r_src;
  logic [WORD_SIZE-1:0] r_reg_val;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [7:0]           r_widx;
  logic                 r_wpend;

  logic                 w_reg_wr;
  logic                 w_run;
  logic                 w_last;
  logic [ADR_WIDTH-1:0] w_dma_adr;

  assign w_reg_wr  = cpu_wr && (cpu_adr == REG_ADR);
  assign w_run     = (r_state == RUN);
  assign w_last    = (r_idx == LAST_IDX);
  assign w_dma_adr = ADR_WIDTH'({r_src, r_idx});

  // Next-state and index: a register write always restarts from START.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_reg_wr) begin
      w_state_nxt = START;
      w_idx_nxt   = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        START: begin
          w_state_nxt = RUN;
          w_idx_nxt   = 8'd0;
        end
        RUN: begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 8'd0;
          end else begin
            w_idx_nxt = r_idx + 8'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 8'd0;
        end
      endcase
    end
  end

  // State and index register, advancing only on M-cycle boundaries.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_idx   <= 8'd0;
    end else if (mcyc) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Latch the register value and the (echo-folded) source page on a write.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_reg_val <= '0;
      r_src     <= 8'd0;
    end else if (mcyc && w_reg_wr) begin
      r_reg_val <= cpu_dout;
      r_src     <= map_src(cpu_dout[7:0]);
    end
  end

  // Capture the byte read this M-cycle so it is written to OAM in the next;
  // this also runs on a restart edge so the in-flight byte still lands.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wdata <= '0;
      r_widx  <= 8'd0;
      r_wpend <= 1'b0;
    end else if (mcyc) begin
      if (w_run) begin
        r_wdata <= mem_din;
        r_widx  <= r_idx;
        r_wpend <= 1'b1;
      end else begin
        r_wpend <= 1'b0;
      end
    end
  end

  assign oam_we   = r_wpend;
  assign oam_adr  = r_widx;
  assign oam_dout = r_wdata;
  assign busy     = w_run || r_wpend;

  sm83_bus_arb #(
    .ADR_WIDTH (ADR_WIDTH),
    .WORD_SIZE (WORD_SIZE),
    .REG_ADR   (REG_ADR)
  ) u_bus_arb (
    .i_run      (w_run),
    .i_dma_adr  (w_dma_adr),
    .i_cpu_adr  (cpu_adr),
    .i_cpu_dout (cpu_dout),
    .i_cpu_rd   (cpu_rd),
    .i_cpu_wr   (cpu_wr),
    .i_reg_val  (r_reg_val),
    .i_mem_din  (mem_din),
    .o_mem_adr  (mem_adr),
    .o_mem_dout (mem_dout),
    .o_mem_rd   (mem_rd),
    .o_mem_wr   (mem_wr),
    .o_cpu_din  (cpu_din)
  );

endmodule

// File: tb/tb_sm83_oam_dma.sv
// Self-checking bench for sm83_oam_dma against a transfer-level model.
module tb_sm83_oam_dma;

  localparam int OAM_LEN = 160;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        mcyc = 1'b0;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_dout;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic [15:0] mem_adr;
  logic [7:0]  mem_dout;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_dout;
  logic        oam_we;
  logic        busy;

  logic [7:0]  memArr [0:65535];
  assign mem_din = memArr[mem_adr];

  int          checks = 0;
  int          errors = 0;
  int          mIndex = 0;
  bit          mcycHold = 1'b0;
  logic [15:0] rdQ[$];
  int          weCount;
  int          busyCnt;
  int          firstBusyM;
  int          wrM;
  logic [7:0]  oamGot [0:255];

  sm83_oam_dma dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .mcyc     (mcyc),
    .cpu_adr  (cpu_adr),
    .cpu_dout (cpu_dout),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_din  (cpu_din),
    .mem_adr  (mem_adr),
    .mem_dout (mem_dout),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .oam_adr  (oam_adr),
    .oam_dout (oam_dout),
    .oam_we   (oam_we),
    .busy     (busy)
  );

  // Free-running clock.
  initial forever #5 clk = ~clk;

  // M-cycle strobe: one clk in four, suppressed while mcycHold is set.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mcycHold) begin
        mcyc = 1'b0;
        cnt  = 0;
      end else begin
        cnt  = (cnt + 1) % 4;
        mcyc = (cnt == 0);
      end
    end
  end

  // Observe every M-cycle boundary: OAM writes, bus reads and busy cycles.
  initial forever begin
    @(posedge clk);
    if (mcyc === 1'b1) begin
      if (oam_we === 1'b1) begin
        oamGot[oam_adr] = oam_dout;
        weCount++;
      end
      if (mem_rd === 1'b1) rdQ.push_back(mem_adr);
      if (busy === 1'b1) begin
        if (busyCnt == 0) firstBusyM = mIndex;
        busyCnt++;
      end
      mIndex++;
    end
  end

  // Global time limit so a stuck design can never hang the run.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] srcOf(input logic [7:0] v);
    if (v >= 8'hE0) return v - 8'h20;
    return v;
  endfunction

  task automatic nextM();
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (mcyc !== 1'b1 && guard < 100);
    #1;
  endtask

  task automatic idleBus();
    cpu_adr  = 16'h0000;
    cpu_dout = 8'h00;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
  endtask

  task automatic clearMon();
    rdQ.delete();
    weCount    = 0;
    busyCnt    = 0;
    firstBusyM = -1;
    for (int i = 0; i < 256; i++) oamGot[i] = 8'hxx;
  endtask

  task automatic startDma(input logic [7:0] v);
    cpu_adr  = 16'hFF46;
    cpu_dout = v;
    cpu_wr   = 1'b1;
    cpu_rd   = 1'b0;
    wrM      = mIndex;
    nextM();
    idleBus();
  endtask

  task automatic advanceTo(input int target);
    int g;
    g = 0;
    while (mIndex < target && g < 1000) begin
      nextM();
      g++;
    end
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int g = 0; g < 400; g++) begin
      if (mIndex > wrM + 2 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      nextM();
    end
  endtask

  task automatic test_reset();
    idleBus();
    #2 n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (oam_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_oam_we: got %b expected 0", oam_we); end
    checks++; if (oam_adr !== 8'h00) begin errors++; $display("[TB] FAIL reset_oam_adr: got %h expected 00", oam_adr); end
    checks++; if (oam_dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_oam_dout: got %h expected 00", oam_dout); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    @(negedge clk);
    n_reset = 1'b1;
    nextM();
    cpu_rd = 1'b1; cpu_adr = 16'hFF46; #1;
    checks++; if (cpu_din !== 8'h00) begin errors++; $display("[TB] FAIL reset_regval: got %h expected 00", cpu_din); end
    idleBus();
  endtask

  task automatic test_full_transfer();
    bit ok;
    int bad;
    for (int i = 0; i < OAM_LEN; i++) memArr[16'hC100 + i] = 8'(i) ^ 8'h5A;
    nextM();
    clearMon();
    startDma(8'hC1);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_start_busy: got %b expected 0", busy); end
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL full_timeout: got busy=%b expected 0", busy); end
    checks++; if (weCount !== OAM_LEN) begin errors++; $display("[TB] FAIL full_we_count: got %0d expected %0d", weCount, OAM_LEN); end
    checks++; if (busyCnt !== OAM_LEN + 1) begin errors++; $display("[TB] FAIL full_busy_len: got %0d expected %0d", busyCnt, OAM_LEN + 1); end
    checks++; if (firstBusyM !== wrM + 2) begin errors++; $display("[TB] FAIL full_busy_start: got M%0d expected M%0d", firstBusyM, wrM + 2); end
    checks++; if (rdQ.size() !== OAM_LEN) begin errors++; $display("[TB] FAIL full_read_count: got %0d expected %0d", rdQ.size(), OAM_LEN); end
    checks++; if (rdQ[0] !== 16'hC100) begin errors++; $display("[TB] FAIL full_first_adr: got %h expected C100", rdQ[0]); end
    bad = 0;
    for (int i = 0; i < OAM_LEN; i++) if (oamGot[i] !== (8'(i) ^ 8'h5A)) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL full_oam: got %0d wrong bytes expected 0", bad); end
  endtask

  task automatic test_echo_map();
    bit ok;
    int bad;
    clearMon();
    startDma(8'hFE);
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL echo_timeout: got busy=%b expected 0", busy); end
    checks++; if (rdQ[0] !== 16'hDE00) begin errors++; $display("[TB] FAIL echo_first_adr: got %h expected DE00", rdQ[0]); end
    checks++; if (rdQ[rdQ.size() - 1] !== 16'hDE9F) begin errors++; $display("[TB] FAIL echo_last_adr: got %h expected DE9F", rdQ[rdQ.size() - 1]); end
    bad = 0;
    for (int i = 0; i < OAM_LEN; i++) if (oamGot[i] !== memArr[16'hDE00 + i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL echo_oam: got %0d wrong bytes expected 0", bad); end
  endtask

  task automatic test_random_sources();
    bit ok;
    int bad;
    logic [7:0] v;
    logic [15:0] base;
    repeat (3) begin
      v = 8'($urandom);
      base = {srcOf(v), 8'h00};
      clearMon();
      startDma(v);
      waitIdle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_timeout: v=%h got busy=%b expected 0", v, busy); end
      checks++; if (rdQ.size() !== OAM_LEN) begin errors++; $display("[TB] FAIL rand_read_count: v=%h got %0d expected %0d", v, rdQ.size(), OAM_LEN); end
      checks++; if (rdQ[0] !== base) begin errors++; $display("[TB] FAIL rand_first_adr: v=%h got %h expected %h", v, rdQ[0], base); end
      bad = 0;
      for (int i = 0; i < OAM_LEN; i++) if (oamGot[i] !== memArr[base + 16'(i)]) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rand_oam: v=%h got %0d wrong bytes expected 0", v, bad); end
    end
  endtask

  task automatic test_blocking();
    bit ok;
    int bad;
    logic [7:0] v;
    logic [15:0] dmaA;
    nextM();
    cpu_rd = 1'b1; cpu_adr = 16'hC000; #1;
    checks++; if (mem_adr !== 16'hC000 || mem_rd !== 1'b1) begin errors++; $display("[TB] FAIL idle_pass_rd: got adr=%h rd=%b expected C000 1", mem_adr, mem_rd); end
    checks++; if (cpu_din !== memArr[16'hC000]) begin errors++; $display("[TB] FAIL idle_pass_din: got %h expected %h", cpu_din, memArr[16'hC000]); end
    idleBus();
    cpu_wr = 1'b1; cpu_adr = 16'hC123; cpu_dout = 8'h77; #1;
    checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'h77) begin errors++; $display("[TB] FAIL idle_pass_wr: got wr=%b dout=%h expected 1 77", mem_wr, mem_dout); end
    idleBus();
    nextM();
    v = 8'($urandom_range(0, 8'hDF));
    clearMon();
    startDma(v);
    advanceTo(wrM + 2 + 30);
    dmaA = {srcOf(v), 8'd30};
    cpu_rd = 1'b1; cpu_adr = 16'hC000; #1;
    checks++; if (cpu_din !== 8'hFF) begin errors++; $display("[TB] FAIL block_rd_din: got %h expected FF", cpu_din); end
    checks++; if (mem_adr !== dmaA || mem_rd !== 1'b1) begin errors++; $display("[TB] FAIL block_rd_bus: got adr=%h rd=%b expected %h 1", mem_adr, mem_rd, dmaA); end
    cpu_adr = 16'hFF80; #1;
    checks++; if (mem_adr !== dmaA) begin errors++; $display("[TB] FAIL ffpage_not_fwd: got %h expected %h", mem_adr, dmaA); end
    cpu_adr = 16'hFF46; #1;
    checks++; if (cpu_din !== v) begin errors++; $display("[TB] FAIL run_regval: got %h expected %h", cpu_din, v); end
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_adr = 16'hC000; cpu_dout = 8'h55; #1;
    checks++; if (mem_wr !== 1'b0 || mem_adr !== dmaA) begin errors++; $display("[TB] FAIL block_wr: got wr=%b adr=%h expected 0 %h", mem_wr, mem_adr, dmaA); end
    nextM();
    idleBus();
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL block_timeout: got busy=%b expected 0", busy); end
    bad = 0;
    for (int i = 0; i < OAM_LEN; i++) if (oamGot[i] !== memArr[{srcOf(v), 8'(i)}]) bad++;
    checks++; if (bad != 0 || weCount !== OAM_LEN) begin errors++; $display("[TB] FAIL block_oam: got %0d wrong, %0d writes expected 0, %0d", bad, weCount, OAM_LEN); end
  endtask

  task automatic test_restart();
    bit ok;
    int bad;
    logic [7:0] v1;
    logic [7:0] exp50;
    v1 = 8'($urandom_range(0, 8'hDF));
    clearMon();
    startDma(v1);
    advanceTo(wrM + 2 + 50);
    exp50 = memArr[{srcOf(v1), 8'd50}];
    startDma(8'hD0);
    #1;
    checks++; if (oam_we !== 1'b1 || oam_adr !== 8'd50) begin errors++; $display("[TB] FAIL restart_pending_we: got we=%b adr=%0d expected 1 50", oam_we, oam_adr); end
    checks++; if (oam_dout !== exp50) begin errors++; $display("[TB] FAIL restart_pending_data: got %h expected %h", oam_dout, exp50); end
    checks++; if (mem_rd !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_start: got rd=%b busy=%b expected 0 1", mem_rd, busy); end
    nextM();
    checks++; if (mem_adr !== 16'hD000 || mem_rd !== 1'b1 || oam_we !== 1'b0) begin errors++; $display("[TB] FAIL restart_first_rd: got adr=%h rd=%b we=%b expected D000 1 0", mem_adr, mem_rd, oam_we); end
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL restart_timeout: got busy=%b expected 0", busy); end
    checks++; if (rdQ.size() !== 51 + OAM_LEN || weCount !== 51 + OAM_LEN) begin errors++; $display("[TB] FAIL restart_counts: got rd=%0d we=%0d expected %0d", rdQ.size(), weCount, 51 + OAM_LEN); end
    checks++; if (rdQ[51] !== 16'hD000 || rdQ[rdQ.size() - 1] !== 16'hD09F) begin errors++; $display("[TB] FAIL restart_adrs: got %h..%h expected D000..D09F", rdQ[51], rdQ[rdQ.size() - 1]); end
    bad = 0;
    for (int i = 0; i < OAM_LEN; i++) if (oamGot[i] !== memArr[16'hD000 + i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL restart_oam: got %0d wrong bytes expected 0", bad); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int bad;
    logic [7:0] v;
    v = 8'($urandom_range(1, 8'hDF));
    clearMon();
    startDma(v);
    advanceTo(wrM + 2 + 80);
    #7 n_reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || oam_we !== 1'b0) begin errors++; $display("[TB] FAIL areset_outputs: got busy=%b we=%b expected 0 0", busy, oam_we); end
    checks++; if (mem_rd !== 1'b0 || oam_adr !== 8'h00) begin errors++; $display("[TB] FAIL areset_bus: got rd=%b oam_adr=%h expected 0 00", mem_rd, oam_adr); end
    @(negedge clk);
    n_reset = 1'b1;
    nextM();
    cpu_rd = 1'b1; cpu_adr = 16'hFF46; #1;
    checks++; if (cpu_din !== 8'h00) begin errors++; $display("[TB] FAIL areset_regval: got %h expected 00", cpu_din); end
    idleBus();
    v = 8'($urandom_range(0, 8'hDF));
    clearMon();
    startDma(v);
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL areset_timeout: got busy=%b expected 0", busy); end
    bad = 0;
    for (int i = 0; i < OAM_LEN; i++) if (oamGot[i] !== memArr[{srcOf(v), 8'(i)}]) bad++;
    checks++; if (bad != 0 || weCount !== OAM_LEN) begin errors++; $display("[TB] FAIL areset_oam: got %0d wrong, %0d writes expected 0, %0d", bad, weCount, OAM_LEN); end
  endtask

  task automatic test_mcyc_hold();
    bit ok;
    int bad;
    logic [7:0] v;
    logic [15:0] dmaA;
    v = 8'($urandom_range(0, 8'hDF));
    clearMon();
    startDma(v);
    advanceTo(wrM + 2 + 20);
    dmaA = {srcOf(v), 8'd20};
    mcycHold = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (mem_adr !== dmaA || mem_rd !== 1'b1) begin errors++; $display("[TB] FAIL hold_adr: got %h rd=%b expected %h 1", mem_adr, mem_rd, dmaA); end
    checks++; if (oam_we !== 1'b1 || oam_adr !== 8'd19) begin errors++; $display("[TB] FAIL hold_we: got we=%b adr=%0d expected 1 19", oam_we, oam_adr); end
    checks++; if (weCount !== 19) begin errors++; $display("[TB] FAIL hold_we_count: got %0d expected 19", weCount); end
    mcycHold = 1'b0;
    waitIdle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_timeout: got busy=%b expected 0", busy); end
    bad = 0;
    for (int i = 0; i < OAM_LEN; i++) if (oamGot[i] !== memArr[{srcOf(v), 8'(i)}]) bad++;
    checks++; if (bad != 0 || weCount !== OAM_LEN) begin errors++; $display("[TB] FAIL hold_oam: got %0d wrong, %0d writes expected 0, %0d", bad, weCount, OAM_LEN); end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    for (int a = 0; a < 65536; a++) memArr[a] = 8'($urandom);
    clearMon();
    test_reset();
    test_full_transfer();
    test_echo_map();
    test_random_sources();
    test_blocking();
    test_restart();
    test_async_reset();
    test_mcyc_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm83_oam_dma.md
Name: sm83_oam_dma

Overview:
- OAM DMA engine and external-bus arbiter between the sm83 core and the memory bus.
- A CPU write to the DMA register (FF46) starts a copy of OAM_LEN bytes from {src,00} to FE00+.
- The copy moves one byte per M-cycle. While it runs, the engine owns the external bus.
- During the copy, CPU accesses outside FF00–FFFF are blocked: reads return FF, writes are dropped.

Parameters:
- ADR_WIDTH, 16, address bus width.
- WORD_SIZE, 8, data width.
- OAM_LEN, 160, bytes per transfer.
- REG_ADR, 16'hFF46, DMA start/source register address.

Ports:
- clk  in  1  CPU clock.
- n_reset  in  1  asynchronous active-low reset.
- mcyc  in  1  one-clk strobe marking the M-cycle boundary. All state advances only on clk edges where mcyc=1.
- cpu_adr  in  ADR_WIDTH  core address.
- cpu_dout  in  WORD_SIZE  core write data.
- cpu_rd  in  1  core read this M-cycle.
- cpu_wr  in  1  core write this M-cycle.
- cpu_din  out  WORD_SIZE  data returned to the core.
- mem_adr  out  ADR_WIDTH  external bus address.
- mem_dout  out  WORD_SIZE  external bus write data.
- mem_rd  out  1  external bus read enable.
- mem_wr  out  1  external bus write enable.
- mem_din  in  WORD_SIZE  external bus read data.
- oam_adr  out  8  OAM byte index.
- oam_dout  out  WORD_SIZE  OAM write data.
- oam_we  out  1  OAM write strobe, one M-cycle wide.
- busy  out  1  transfer in progress: RUN, or a write still pending.

Behaviour:
- Reset, asynchronous on n_reset=0:
  - state=IDLE, idx=0, src=0, reg_val=0, wpend=0, wdata=0.
  - Outputs: busy=0, oam_we=0, oam_adr=0, oam_dout=0, mem_rd=0, mem_wr=0.
- States: IDLE, START, RUN.
  - IDLE→START: on a mcyc edge with cpu_wr=1 and cpu_adr=REG_ADR.
  - START→RUN: on the next mcyc edge; idx=0.
  - RUN: idx increments each mcyc. At idx=OAM_LEN-1 the edge goes RUN→IDLE.
  - A register write in START or RUN restarts the sequence: →START, new src. A transfer in flight is abandoned; the pending write still completes.
- On a register write, latch reg_val=cpu_dout. The source high byte is src=cpu_dout, except values E0–FF, which map to src=cpu_dout&DF (echo RAM → C000).
- RUN read cycle, during the M-cycle with idx=k:
  - mem_adr={src,k}, mem_rd=1, mem_wr=0.
  - At the closing mcyc edge, capture wdata=mem_din, widx=k, wpend=1.
- Write stage: during the M-cycle after a capture, oam_we=1, oam_adr=widx, oam_dout=wdata. wpend clears at the following mcyc edge unless another capture happens.
- Latency:
  - Register write in M-cycle 0 → START in M1 → reads in M2..M(OAM_LEN+1).
  - OAM writes in M3..M(OAM_LEN+2).
  - busy is high M2..M(OAM_LEN+2) inclusive; it is 0 in START.
- Bus ownership:
  - When state≠RUN, the core passes through: mem_adr=cpu_adr, mem_dout=cpu_dout, mem_rd=cpu_rd, mem_wr=cpu_wr, cpu_din=mem_din.
  - When state=RUN and cpu_adr[15:8]=FF, the core's access is allowed. It is not forwarded to mem, because FF page is internal to the SoC.
  - When state=RUN and the address is elsewhere, the access is blocked: cpu_din=FF, write dropped.
- Register readback: a cpu_rd at REG_ADR returns reg_val in any state.
- mcyc=0 edges hold all state. Zero-length OAM_LEN is illegal.

Decomposition:
- Package sm83_pkg: word_t/adr_t typedefs, dma_state_t enum {IDLE,START,RUN}, REG_ADR and OAM_BASE (FE00) constants.
- Sub-module sm83_bus_arb: the combinational ownership mux plus the FF-page decode. Everything else stays in the top.

Test Plan:
- Write 0xC1 to FF46 with mem holding C100+i = i^5A → OAM[i]=i^5A for i=0..159. busy is high exactly 161 M-cycles starting 2 after the write. Exactly 160 oam_we pulses.
- Write 0xFE → source high byte 0xDE. The first mem_adr in RUN is DE00 and the last is DE9F.
- During RUN, the core reads C000 → cpu_din=FF and mem_adr is the DMA address. The core reads FF80 → the access is allowed and not forwarded. The core writes C000 → mem_wr stays with DMA and the write is dropped.
- Restart at idx=50 with value 0xD0 → the write for idx 50 (captured in the edge) completes. A START cycle follows, then reads begin at D000 with idx=0. The transfer ends 160 reads later.
- Assert n_reset mid-RUN at idx=80 → all outputs drop immediately: busy=0, oam_we=0. An FF46 read then returns 00. A new write performs a full transfer.
- mcyc held low for 10 clks during RUN → no state change. idx and oam_we hold.
